fp_to_linear: RTL and testbench
===============================

Name: fp_to_linear

Overview:
- Sequential decoder for the team's 13-bit linear-to-floating-point encoding, working in the reverse direction.
- Accepts {S, E[2:0], F[4:0]} and reconstructs the 13-bit two's-complement value D = (-1)^S * F * 2^E.
- Uses a valid/ready handshake on both sides, with one shift per clock, so it can sit behind a register file or serial link in the display/test datapath.

Parameters:
- DATA_W, 13, output width; must satisfy DATA_W >= MAN_W + 2^EXP_W.
- EXP_W, 3, exponent width.
- MAN_W, 5, significand width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- S  in  1  sign bit.
- E  in  EXP_W  exponent.
- F  in  MAN_W  significand.
- out_valid  out  1  D is valid.
- out_ready  in  1  consumer accepts D.
- D  out  DATA_W  reconstructed two's-complement value.
- noncanon  out  1  the accepted word was not normalized (E>0 and F[MAN_W-1]==0).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - in_ready=1, out_valid=0, D=0, noncanon=0.
  - Internal mag, cnt and sign are all cleared.
- States: IDLE, SHIFT, SIGN, DONE.
- in_ready = (state==IDLE), registered-equivalent. in_valid is ignored outside IDLE.
- IDLE, on in_valid at an edge (accept edge):
  - mag <= zero-extended F (DATA_W bits).
  - cnt <= E, sign <= S.
  - noncanon <= (E!=0 && F[MAN_W-1]==0).
  - state <= SHIFT.
- SHIFT:
  - If cnt!=0: mag <= mag<<1, cnt <= cnt-1.
  - If cnt==0: state <= SIGN.
  - Exactly E shift cycles.
- SIGN:
  - D <= sign ? (~mag+1) : mag, truncated to DATA_W.
  - out_valid <= 1, state <= DONE.
- DONE:
  - D, noncanon and out_valid are held stable while out_ready==0.
  - On out_ready==1: out_valid <= 0, state <= IDLE.
- Latency: out_valid rises at the edge E+2 after the accept edge. Minimum spacing between accepts is E+4 cycles.
- Arithmetic:
  - Maximum magnitude is 31*128 = 3968, which fits without overflow. Overflow or saturation logic is neither needed nor present.
  - S=1 with F=0 gives D=0 (no negative zero).
- noncanon is informational only. The value is still computed as F*2^E. The flag updates only at an accept edge.
- Outputs are held between transactions. D and noncanon keep their last values in IDLE; only out_valid qualifies them.
- Reset mid-operation (any state):
  - Returns immediately to the reset values.
  - Any in-flight word is discarded and no out_valid is produced for it.
- An in_valid asserted during the reset release cycle is not accepted until the first edge with rst_n=1 and state=IDLE.

Test Plan:
- Reset, then S=0 E=0 F=5 with in_valid pulse -> out_valid 2 cycles after accept, D=13'h0005, noncanon=0.
- S=0 E=7 F=31 -> out_valid 9 cycles after accept, D=3968 (13'h0F80).
- S=1 E=7 F=31 -> D=13'h1080 (-3968). Separately, S=1 E=3 F=20 -> D=13'h1F60 (-160), latency 5.
- S=1 E=0 F=0 -> D=0. Then S=0 E=2 F=5 -> D=20, noncanon=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid.
  - Required: D and out_valid stable and in_ready=0 throughout.
  - in_valid with a new word during that window is ignored.
  - out_ready=1 -> IDLE next cycle, and the next accept proceeds normally.
- Drive rst_n low during SHIFT of an E=6 word -> out_valid stays 0, D=0, in_ready=1 immediately (async). No stale output appears after release.

Source files
------------

// File: rtl/fp_to_linear.sv
// Sequential floating-point to linear decoder: {S,E,F} -> D = (-1)^S * F * 2^E.
// One left shift per clock, valid/ready handshake on input and output.
module fp_to_linear #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned EXP_W  = 3,
    parameter int unsigned MAN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [MAN_W-1:0]  F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] D,
    output logic              noncanon
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mag_q, mag_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [DATA_W-1:0]  d_q, d_d;
    logic               nc_q, nc_d;
    logic               ov_q, ov_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            d_q     <= '0;
            nc_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            d_q     <= d_d;
            nc_q    <= nc_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state and datapath update; D and noncanon hold between transactions
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        d_d     = d_q;
        nc_d    = nc_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d   = DATA_W'(F);
                    cnt_d   = E;
                    sign_d  = S;
                    nc_d    = (E != '0) && !F[MAN_W-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                d_d     = sign_q ? (~mag_q + DATA_W'(1)) : mag_q;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign D         = d_q;
    assign noncanon  = nc_q;

endmodule

// File: tb/tb_fp_to_linear.sv
// Self-checking bench for fp_to_linear: directed cases plus random traffic,
// compared every cycle against a transaction-level timing/value model.
module tb_fp_to_linear;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [4:0]  F = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [12:0] D;
    logic        noncanon;

    int nvec = 0;
    int nerr = 0;

    fp_to_linear dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .noncanon(noncanon)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value reference: signed integer arithmetic, wrapped to 13 bits
    function automatic logic [12:0] ref_d(input bit s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s) v = -v;
        return 13'(v);
    endfunction

    function automatic bit ref_nc(input int e, input int f);
        return (e != 0) && (f < 16);
    endfunction

    // Cycle-level model: busy from accept until output handed off
    bit          m_busy = 0;
    bit          m_valid = 0;
    int          m_rem = 0;
    logic [12:0] m_pend = '0;
    logic [12:0] m_d = '0;
    bit          m_nc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_rem = 0; m_d = '0; m_nc = 0;
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_D", int'(D), 0);
            check("rst_noncanon", int'(noncanon), 0);
        end else begin
            check("in_ready", int'(in_ready), int'(!m_busy));
            check("out_valid", int'(out_valid), int'(m_valid));
            check("D", int'(D), int'(m_d));
            check("noncanon", int'(noncanon), int'(m_nc));
            // predict the effect of the coming rising edge
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1;
                    m_rem  = int'(E) + 2;
                    m_pend = ref_d(S, int'(E), int'(F));
                    m_nc   = ref_nc(int'(E), int'(F));
                end
            end else if (!m_valid) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_valid = 1;
                    m_d = m_pend;
                end
            end else if (out_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word, measure latency, check result against literals
    task automatic send(input bit s, input int e, input int f,
                        input int exp_d, input int exp_nc);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin tick(); guard++; end
        check("accept_timeout", int'(in_ready), 1);
        in_valid = 1'b1; S = s; E = 3'(e); F = 5'(f);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check("latency", lat, e + 2);
        check("lit_D", int'(D), exp_d);
        check("lit_noncanon", int'(noncanon), exp_nc);
    endtask

    initial begin
        logic [12:0] held;

        // pin the reference itself
        check("ref_5",     int'(ref_d(0, 0, 5)),  13'h0005);
        check("ref_3968",  int'(ref_d(0, 7, 31)), 13'h0F80);
        check("ref_m3968", int'(ref_d(1, 7, 31)), 13'h1080);
        check("ref_m160",  int'(ref_d(1, 3, 20)), 13'h1F60);
        check("ref_nz",    int'(ref_d(1, 0, 0)),  13'h0000);
        check("ref_nc",    int'(ref_nc(2, 5)),    1);

        // in_valid held across reset release must only be taken once idle
        in_valid = 1'b1; S = 1'b0; E = 3'd1; F = 5'd17;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();

        send(0, 0, 5,  13'h0005, 0);
        send(0, 7, 31, 13'h0F80, 0);
        send(1, 7, 31, 13'h1080, 0);
        send(1, 3, 20, 13'h1F60, 0);
        send(1, 0, 0,  13'h0000, 0);
        send(0, 2, 5,  13'd20,   1);
        tick();

        // backpressure: output frozen, new word ignored
        out_ready = 1'b0;
        send(0, 4, 19, 13'd304, 0);
        held = D;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; S = 1'b1; E = 3'd1; F = 5'd3;
            tick();
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_D", int'(D), int'(held));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", int'(in_ready), 1);
        check("bp_release_valid", int'(out_valid), 0);
        send(1, 1, 16, 13'h1FE0, 0);
        tick();

        // reset in the middle of a shift sequence
        in_valid = 1'b1; S = 1'b0; E = 3'd6; F = 5'd9;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_D", int'(D), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_no_valid", int'(out_valid), 0);
        end

        // random traffic with random backpressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            S         = 1'($urandom);
            E         = 3'($urandom);
            F         = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
